tiro_nave: RTL and testbench
============================

Name: tiro_nave

Overview:
Ally-shot controller that sits directly downstream of the ship block and consumes its position and size outputs. On a fire request it launches a single projectile from the ship's nose and steps it upward at a fixed rate. The shot is removed when it leaves the top of the play area or when the collision logic reports a hit, and a reload cooldown then runs before the next launch. Its position and radius outputs feed the renderer and the collision logic.

Parameters:
PASSO, 2, pixels moved upward per movement step
DIV_MOV, 250000, CLOCK_50 cycles per movement step (24-bit counter, must be >= 1)
RAIO, 5, projectile radius in pixels
Y_MIN, 0, top boundary of the play area (pixel row)
CADENCIA, 12500000, reload cooldown in CLOCK_50 cycles (24-bit counter, must be >= 1)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetNave  in  1  asynchronous reset, active-high
pausa  in  1  1 = freeze all state, counters and position
disparar  in  1  fire request (level from key conditioning)
x_nave  in  10  ship left x
y_nave  in  10  ship top y
largura_nave  in  10  ship width
acerto  in  1  hit report from collision logic, level-sampled
x  out  10  projectile centre x
y  out  10  projectile centre y
raio  out  10  constant RAIO
ativo  out  1  projectile in flight
disparou  out  1  one-cycle pulse on launch
saiu  out  1  one-cycle pulse on exit through the top

Behaviour:
- Reset (async, resetNave=1): state OCIOSO; x=0, y=0, ativo=0, disparou=0, saiu=0; movement and cooldown counters =0; disparar_q=0. Reset mid-flight aborts the shot immediately with no pulse.
- disparar_q registers disparar every cycle, including during pausa. A fire edge is disparar=1 && disparar_q=0.
- Pulses disparou and saiu default to 0 every cycle; each is high for exactly one cycle when set.
- OCIOSO: ativo=0. On a clock edge with a fire edge and pausa=0:
  - x <= x_nave + (largura_nave>>1), mod 1024;
  - y <= y_nave - RAIO, or 0 if y_nave < RAIO;
  - ativo <= 1, disparou <= 1, movement counter <= 0, go to VOANDO.
  - The outputs therefore become visible one cycle after the first sampled disparar=1.
  - A fire edge that arrives while pausa=1 is lost.
- VOANDO: x is held (ship motion does not steer the shot).
  - pausa=1: nothing changes and acerto is ignored.
  - pausa=0, priority order:
    - (1) acerto=1: ativo <= 0, go to RECARGA, cooldown <= 0, no saiu pulse, y unchanged.
    - (2) Otherwise the movement counter increments. When it equals DIV_MOV-1 it resets to 0 and a step occurs:
      - if y < Y_MIN + PASSO: saiu <= 1, ativo <= 0, y unchanged, go to RECARGA, cooldown <= 0;
      - else y <= y - PASSO.
  - The first step lands DIV_MOV cycles after launch.
- RECARGA: ativo=0.
  - The cooldown counter increments while pausa=0 and freezes while pausa=1.
  - When it equals CADENCIA-1, go to OCIOSO.
  - Fire edges in this state are discarded, not queued.
- x and y hold their last values while the shot is inactive.
- raio = RAIO at all times, zero-extended to 10 bits.
- The state encoding is free. Unreachable encodings recover to OCIOSO.

Optional Feature:
TIRO_AUTO_EN
- Defined: in OCIOSO the launch condition is disparar=1 (level) instead of a fire edge, so holding fire re-launches on the first OCIOSO cycle after each cooldown.
- Undefined: launch requires a fire edge, and held fire produces exactly one shot.

Test Plan:
All scenarios use DIV_MOV=4, PASSO=2, RAIO=5, CADENCIA=8, Y_MIN=0.
1. Reset: assert resetNave mid-cycle -> x=0, y=0, ativo=0, disparou=0, saiu=0 immediately, with no clock edge needed.
2. Launch: x_nave=350, y_nave=420, largura_nave=30; raise disparar for 1 cycle -> next cycle x=365, y=415, ativo=1, disparou=1 for exactly 1 cycle. y=413 at 4 cycles after launch and y=411 at 8. x stays 365 while x_nave changes.
3. Pause: pausa=1 for 10 cycles mid-flight with acerto=1 pulsed inside the window -> y and the counters are frozen and the hit is ignored. Stepping resumes with the same phase after pausa=0.
4. Hit: acerto=1 for 1 cycle in VOANDO -> ativo=0 next cycle, saiu stays 0. A fire edge within the following 8 cycles is ignored. A fire edge after 8 unpaused cycles launches.
5. Top exit: launch with y_nave=8 (y=3) -> steps to y=1, then the next step gives saiu=1 for 1 cycle, ativo=0, y=1 held.
6. Edge-only, feature off: hold disparar=1 for 100 cycles -> exactly one disparou pulse. With TIRO_AUTO_EN defined and acerto forcing quick hits -> a new disparou follows each 8-cycle cooldown.

Source files
------------

// File: rtl/tiro_nave.sv
// Ally-shot controller: launches one projectile from the ship's nose and steps it upward until exit or hit, then reloads.
// Optional TIRO_AUTO_EN: launch on fire level instead of fire edge, so held fire auto-repeats after each cooldown.
module tiro_nave #(
  parameter int unsigned PASSO    = 2,
  parameter int unsigned DIV_MOV  = 250000,
  parameter int unsigned RAIO     = 5,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned CADENCIA = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       resetNave,
  input  logic       pausa,
  input  logic       disparar,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] largura_nave,
  input  logic       acerto,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] raio,
  output logic       ativo,
  output logic       disparou,
  output logic       saiu
);

  localparam logic [23:0] MOV_FIM = 24'(DIV_MOV - 1);
  localparam logic [23:0] REC_FIM = 24'(CADENCIA - 1);
  localparam logic [9:0]  RAIO_V  = 10'(RAIO);
  localparam logic [9:0]  PASSO_V = 10'(PASSO);
  // One extra bit so Y_MIN + PASSO cannot wrap against a 10-bit row.
  localparam logic [10:0] Y_LIM   = 11'(Y_MIN + PASSO);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    VOANDO  = 2'd1,
    RECARGA = 2'd2
  } estado_t;

  estado_t     estado;
  logic [23:0] cnt_mov;
  logic [23:0] cnt_rec;
  logic        disparar_q;
  logic        lanca;
  logic [9:0]  x_lanc;
  logic [9:0]  y_lanc;

`ifdef TIRO_AUTO_EN
  assign lanca = disparar;
`else
  assign lanca = disparar & ~disparar_q;
`endif

  // Nose position: horizontal centre of the ship, just above its top edge, clamped at row 0.
  assign x_lanc = x_nave + (largura_nave >> 1);
  assign y_lanc = (y_nave < RAIO_V) ? 10'd0 : y_nave - RAIO_V;
  assign raio   = RAIO_V;

  // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
  always_ff @(posedge CLOCK_50 or posedge resetNave) begin
    if (resetNave) begin
      estado     <= OCIOSO;
      x          <= '0;
      y          <= '0;
      ativo      <= 1'b0;
      disparou   <= 1'b0;
      saiu       <= 1'b0;
      cnt_mov    <= '0;
      cnt_rec    <= '0;
      disparar_q <= 1'b0;
    end else begin
      disparar_q <= disparar;
      disparou   <= 1'b0;
      saiu       <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (!pausa && lanca) begin
            x        <= x_lanc;
            y        <= y_lanc;
            ativo    <= 1'b1;
            disparou <= 1'b1;
            cnt_mov  <= '0;
            estado   <= VOANDO;
          end
        end
        VOANDO: begin
          if (!pausa) begin
            if (acerto) begin
              ativo   <= 1'b0;
              cnt_rec <= '0;
              estado  <= RECARGA;
            end else if (cnt_mov == MOV_FIM) begin
              cnt_mov <= '0;
              if ({1'b0, y} < Y_LIM) begin
                saiu    <= 1'b1;
                ativo   <= 1'b0;
                cnt_rec <= '0;
                estado  <= RECARGA;
              end else begin
                y <= y - PASSO_V;
              end
            end else begin
              cnt_mov <= cnt_mov + 24'd1;
            end
          end
        end
        RECARGA: begin
          if (!pausa) begin
            if (cnt_rec == REC_FIM) begin
              estado <= OCIOSO;
            end else begin
              cnt_rec <= cnt_rec + 24'd1;
            end
          end
        end
        default: begin
          ativo  <= 1'b0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiro_nave.sv
// Directed bench for tiro_nave with DIV_MOV=4, PASSO=2, RAIO=5, CADENCIA=8, Y_MIN=0.
// Build with TIRO_AUTO_EN defined to check the auto-fire variant of the held-fire scenario.
module tb_tiro_nave;

  logic       CLOCK_50;
  logic       resetNave;
  logic       pausa;
  logic       disparar;
  logic [9:0] x_nave;
  logic [9:0] y_nave;
  logic [9:0] largura_nave;
  logic       acerto;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] raio;
  logic       ativo;
  logic       disparou;
  logic       saiu;

  int vec_count  = 0;
  int miss_count = 0;

  tiro_nave #(
    .PASSO(2), .DIV_MOV(4), .RAIO(5), .Y_MIN(0), .CADENCIA(8)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetNave(resetNave), .pausa(pausa), .disparar(disparar),
    .x_nave(x_nave), .y_nave(y_nave), .largura_nave(largura_nave), .acerto(acerto),
    .x(x), .y(y), .raio(raio), .ativo(ativo), .disparou(disparou), .saiu(saiu)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance one edge and settle 1 ns past it: inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Ends a flight with a hit and waits out the full cooldown, leaving the DUT idle.
  task automatic abort_and_cool();
    acerto = 1'b1;
    tick();
    acerto = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    #1;
    vec_count++;
    if ({x, y, ativo, disparou, saiu} !== 23'd0) begin
      miss_count++;
      $display("FAIL reset_state: got x=%0d y=%0d ativo=%0b disparou=%0b saiu=%0b, expected all 0", x, y, ativo, disparou, saiu);
    end
    vec_count++;
    if (raio !== 10'd5) begin
      miss_count++;
      $display("FAIL raio_const: got %0d, expected 5", raio);
    end
    tick();
    tick();
    resetNave = 1'b0;
    disparar = 1'b1;
    tick();
    vec_count++;
    if (ativo !== 1'b1 || disparou !== 1'b1) begin
      miss_count++;
      $display("FAIL reset_prelaunch: got ativo=%0b disparou=%0b, expected 1 1", ativo, disparou);
    end
    // Asynchronous reset in the middle of a cycle, mid-flight.
    #3;
    resetNave = 1'b1;
    #1;
    vec_count++;
    if ({x, y, ativo, disparou, saiu} !== 23'd0) begin
      miss_count++;
      $display("FAIL reset_async: got x=%0d y=%0d ativo=%0b disparou=%0b saiu=%0b, expected all 0", x, y, ativo, disparou, saiu);
    end
    disparar = 1'b0;
    tick();
    resetNave = 1'b0;
    tick();
    vec_count++;
    if (ativo !== 1'b0 || disparou !== 1'b0) begin
      miss_count++;
      $display("FAIL reset_release: got ativo=%0b disparou=%0b, expected 0 0", ativo, disparou);
    end
  endtask

  task automatic test_launch();
    x_nave = 10'd350;
    y_nave = 10'd420;
    largura_nave = 10'd30;
    disparar = 1'b1;
    tick();
    vec_count++;
    if (x !== 10'd365 || y !== 10'd415) begin
      miss_count++;
      $display("FAIL launch_pos: got x=%0d y=%0d, expected x=365 y=415", x, y);
    end
    vec_count++;
    if (ativo !== 1'b1 || disparou !== 1'b1) begin
      miss_count++;
      $display("FAIL launch_flags: got ativo=%0b disparou=%0b, expected 1 1", ativo, disparou);
    end
    disparar = 1'b0;
    tick();
    vec_count++;
    if (disparou !== 1'b0) begin
      miss_count++;
      $display("FAIL launch_pulse_width: got disparou=%0b, expected 0", disparou);
    end
    x_nave = 10'd100;
    tick();
    tick();
    vec_count++;
    if (y !== 10'd415) begin
      miss_count++;
      $display("FAIL step_early: got y=%0d at 3 cycles, expected 415", y);
    end
    tick();
    vec_count++;
    if (y !== 10'd413 || x !== 10'd365) begin
      miss_count++;
      $display("FAIL step_first: got x=%0d y=%0d at 4 cycles, expected x=365 y=413", x, y);
    end
    repeat (4) tick();
    vec_count++;
    if (y !== 10'd411 || x !== 10'd365) begin
      miss_count++;
      $display("FAIL step_second: got x=%0d y=%0d at 8 cycles, expected x=365 y=411", x, y);
    end
  endtask

  task automatic test_pause();
    // Two cycles into the step period, then freeze for ten cycles with a hit inside.
    tick();
    tick();
    pausa = 1'b1;
    tick();
    tick();
    acerto = 1'b1;
    tick();
    acerto = 1'b0;
    repeat (7) tick();
    vec_count++;
    if (y !== 10'd411 || ativo !== 1'b1) begin
      miss_count++;
      $display("FAIL pause_freeze: got y=%0d ativo=%0b, expected y=411 ativo=1", y, ativo);
    end
    pausa = 1'b0;
    tick();
    vec_count++;
    if (y !== 10'd411) begin
      miss_count++;
      $display("FAIL pause_phase_early: got y=%0d, expected 411", y);
    end
    tick();
    vec_count++;
    if (y !== 10'd409 || ativo !== 1'b1) begin
      miss_count++;
      $display("FAIL pause_phase_step: got y=%0d ativo=%0b, expected y=409 ativo=1", y, ativo);
    end
  endtask

  task automatic test_hit();
    acerto = 1'b1;
    tick();
    acerto = 1'b0;
    vec_count++;
    if (ativo !== 1'b0 || saiu !== 1'b0 || y !== 10'd409) begin
      miss_count++;
      $display("FAIL hit: got ativo=%0b saiu=%0b y=%0d, expected 0 0 409", ativo, saiu, y);
    end
    disparar = 1'b1;
    tick();
    disparar = 1'b0;
    vec_count++;
    if (ativo !== 1'b0 || disparou !== 1'b0) begin
      miss_count++;
      $display("FAIL cooldown_early_fire: got ativo=%0b disparou=%0b, expected 0 0", ativo, disparou);
    end
    repeat (6) tick();
    // Fire edge on the last cooldown edge is still discarded.
    disparar = 1'b1;
    tick();
    disparar = 1'b0;
    vec_count++;
    if (ativo !== 1'b0 || disparou !== 1'b0) begin
      miss_count++;
      $display("FAIL cooldown_last_fire: got ativo=%0b disparou=%0b, expected 0 0", ativo, disparou);
    end
    tick();
    disparar = 1'b1;
    tick();
    disparar = 1'b0;
    vec_count++;
    if (disparou !== 1'b1 || ativo !== 1'b1 || x !== 10'd115 || y !== 10'd415) begin
      miss_count++;
      $display("FAIL relaunch: got disparou=%0b ativo=%0b x=%0d y=%0d, expected 1 1 115 415", disparou, ativo, x, y);
    end
  endtask

  task automatic test_top_exit();
    abort_and_cool();
    x_nave = 10'd350;
    y_nave = 10'd8;
    disparar = 1'b1;
    tick();
    disparar = 1'b0;
    vec_count++;
    if (y !== 10'd3 || x !== 10'd365 || ativo !== 1'b1) begin
      miss_count++;
      $display("FAIL exit_launch: got x=%0d y=%0d ativo=%0b, expected 365 3 1", x, y, ativo);
    end
    repeat (4) tick();
    vec_count++;
    if (y !== 10'd1 || saiu !== 1'b0) begin
      miss_count++;
      $display("FAIL exit_step: got y=%0d saiu=%0b, expected 1 0", y, saiu);
    end
    repeat (4) tick();
    vec_count++;
    if (saiu !== 1'b1 || ativo !== 1'b0 || y !== 10'd1) begin
      miss_count++;
      $display("FAIL exit_pulse: got saiu=%0b ativo=%0b y=%0d, expected 1 0 1", saiu, ativo, y);
    end
    tick();
    vec_count++;
    if (saiu !== 1'b0 || y !== 10'd1) begin
      miss_count++;
      $display("FAIL exit_hold: got saiu=%0b y=%0d, expected 0 1", saiu, y);
    end
  endtask

  task automatic test_clamp();
    // Exit happened one edge ago; the cooldown ends on the 8th edge after it.
    repeat (7) tick();
    x_nave = 10'd1000;
    y_nave = 10'd3;
    largura_nave = 10'd60;
    disparar = 1'b1;
    tick();
    disparar = 1'b0;
    vec_count++;
    if (disparou !== 1'b1 || x !== 10'd6 || y !== 10'd0) begin
      miss_count++;
      $display("FAIL clamp_launch: got disparou=%0b x=%0d y=%0d, expected 1 6 0", disparou, x, y);
    end
    repeat (4) tick();
    vec_count++;
    if (saiu !== 1'b1 || ativo !== 1'b0 || y !== 10'd0) begin
      miss_count++;
      $display("FAIL clamp_exit: got saiu=%0b ativo=%0b y=%0d, expected 1 0 0", saiu, ativo, y);
    end
    repeat (8) tick();
  endtask

  task automatic test_hold_fire();
    int n_pulses;
    int first_at;
    int last_at;
    int bad_gap;
    n_pulses = 0;
    first_at = 0;
    last_at = 0;
    bad_gap = 0;
    x_nave = 10'd350;
    y_nave = 10'd420;
    largura_nave = 10'd30;
    disparar = 1'b1;
    acerto = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (disparou === 1'b1) begin
        n_pulses++;
        if (first_at == 0) first_at = i;
        else if (i - last_at != 10) bad_gap++;
        last_at = i;
      end
    end
    disparar = 1'b0;
    acerto = 1'b0;
    vec_count++;
    if (first_at != 1) begin
      miss_count++;
      $display("FAIL hold_first: got first pulse at cycle %0d, expected 1", first_at);
    end
`ifdef TIRO_AUTO_EN
    vec_count++;
    if (n_pulses != 10) begin
      miss_count++;
      $display("FAIL auto_count: got %0d pulses, expected 10", n_pulses);
    end
    vec_count++;
    if (bad_gap != 0) begin
      miss_count++;
      $display("FAIL auto_period: got %0d gaps other than 10 cycles, expected 0", bad_gap);
    end
`else
    vec_count++;
    if (n_pulses != 1) begin
      miss_count++;
      $display("FAIL hold_single: got %0d pulses, expected 1", n_pulses);
    end
`endif
  endtask

  initial begin
    resetNave = 1'b1;
    pausa = 1'b0;
    disparar = 1'b0;
    acerto = 1'b0;
    x_nave = 10'd350;
    y_nave = 10'd420;
    largura_nave = 10'd30;
    test_reset();
    test_launch();
    test_pause();
    test_hit();
    test_top_exit();
    test_clamp();
    test_hold_fire();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
